// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared types and frame-timing helpers for the UART TX path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int UART_CLKS_PER_BIT_DFLT = 217;
  localparam int UART_FRAME_BITS        = 10;

  function automatic int frame_cycles(input int cpb, input int bits);
    return cpb * bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
//------------------------------------------------------------------------------
// uart_tx_scheduler_if : producer request bus and uart_tx-facing outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic [IDX_W-1:0]     grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data, tx_valid, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data, tx_valid, grant_id, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin picker, search starts at ptr+1
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  wire logic [N-1:0]     req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic      [N-1:0]     gnt_onehot,
  output logic      [IDX_W-1:0] gnt_idx,
  output logic                  any
);

  // Offset k=1 is the requester just after the last winner; k=N wraps to ptr itself.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
          any           = 1'b1;
          gnt_onehot[i] = 1'b1;
          gnt_idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
//------------------------------------------------------------------------------
// uart_tx_scheduler : round-robin sharing of one uart_tx between NUM_REQ producers
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT,
  parameter int FRAME_BITS   = UART_FRAME_BITS
) (
  input wire logic           clk,
  input wire logic           rst_n,
  uart_tx_scheduler_if.slave bus
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int HOLD_CYC = frame_cycles(CLKS_PER_BIT, FRAME_BITS);
  localparam int CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [7:0]       r_tx_data;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic [7:0]         w_req_bytes [NUM_REQ];
  logic [7:0]         w_sel_data;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_bytes[g] = bus.req_data[8*g +: 8];
    end
  endgenerate

  assign w_sel_data = w_req_bytes[w_gnt_idx];

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req        (bus.req_valid),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Reset lands in HOLD so a frame already leaving uart_tx is allowed to finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= HOLD;
      r_hold_cnt <= HOLD_LOAD;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_rr_ptr   <= PTR_RESET;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tx_data  <= w_sel_data;
            r_grant_id <= w_gnt_idx;
            r_rr_ptr   <= w_gnt_idx;
          end
        end
        ISSUE: r_hold_cnt <= HOLD_LOAD;
        HOLD: begin
          if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        default: r_hold_cnt <= HOLD_LOAD;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    bus.req_ready = '0;
    case (r_state)
      IDLE: begin
        if (rst_n) bus.req_ready = w_gnt_onehot;
        if (w_any) w_next_state = ISSUE;
      end
      ISSUE:   w_next_state = HOLD;
      HOLD:    if (r_hold_cnt == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.tx_valid = (r_state == ISSUE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.tx_data  = r_tx_data;
  assign bus.grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
//------------------------------------------------------------------------------
// tb_uart_tx_scheduler : scoreboard bench for uart_tx_scheduler (CPB=4, 10 bits)
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int CPB      = 4;
  localparam int FB       = 10;
  localparam int HOLD_CYC = CPB * FB;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  txn_t sb[$];
  int   exp_grant[$];
  int   tx_cycles[$];

  logic [7:0]         pend_mem [NUM_REQ][16];
  int                 wr_p [NUM_REQ];
  int                 rd_p [NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic [NUM_REQ-1:0] ready_seen = '0;
  int                 last_acc_cyc = -10;
  logic               prev_tx = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] d);
    pend_mem[id][wr_p[id] % 16] = d;
    wr_p[id]++;
  endtask

  // Requester model: hold valid/data until accepted, then present the next byte.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_mask[i]) rd_p[i]++;
    end
    acc_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]        = (rd_p[i] < wr_p[i]);
      bus.req_data[8*i +: 8]  = (rd_p[i] < wr_p[i]) ? pend_mem[i][rd_p[i] % 16] : 8'h00;
    end
  end

  always @(negedge clk) begin
    int   w;
    txn_t t;
    w = 0;
    if (!rst_n) begin
      check_eq("ready_in_reset", 32'(bus.req_ready), 0);
      prev_tx = 1'b0;
    end else begin
      if (bus.busy && bus.req_valid != '0)
        check_eq("ready_while_busy", 32'(bus.req_ready), 0);
      if (bus.req_ready != '0) begin
        ready_seen = ready_seen | bus.req_ready;
        check_eq("ready_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) w = i;
        check_eq("ready_valid", 32'(bus.req_valid[w]), 1);
        acc_mask = bus.req_ready & bus.req_valid;
        if (exp_grant.size() == 0) check_eq("unexpected_grant", w, 32'hFFFF_FFFF);
        else check_eq("grant_order", w, exp_grant.pop_front());
        sb.push_back({pend_mem[w][rd_p[w] % 16], 2'(w)});
        last_acc_cyc = cyc;
      end
      if (bus.tx_valid) begin
        check_eq("tx_width", 32'(prev_tx), 0);
        check_eq("tx_latency", cyc, last_acc_cyc + 1);
        tx_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          check_eq("sb_empty", sb.size(), 1);
        end else begin
          t = sb.pop_front();
          check_eq("tx_data", 32'(bus.tx_data), 32'(t.data));
          check_eq("grant_id", 32'(bus.grant_id), 32'(t.id));
        end
      end
      prev_tx = bus.tx_valid;
    end
  end

  function automatic bit nothing_pending();
    for (int i = 0; i < NUM_REQ; i++) if (rd_p[i] != wr_p[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag, input int bound);
    bit done;
    done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      @(negedge clk);
      if (exp_grant.size() == 0 && sb.size() == 0 && !bus.busy && nothing_pending())
        done = 1'b1;
    end
    check_eq(tag, 32'(done), 1);
  endtask

  task automatic wait_tx(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 1);
  endtask

  // After release: HOLD_CYC cycles busy with no ready and no tx_valid, then IDLE.
  task automatic check_release(input string tag, input logic [NUM_REQ-1:0] exp_ready);
    int bad;
    bad = 0;
    for (int n = 0; n < HOLD_CYC; n++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.req_ready !== '0 || bus.tx_valid !== 1'b0) bad++;
    end
    check_eq({tag, "_hold"}, bad, 0);
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(bus.busy), 0);
    check_eq({tag, "_first_ready"}, 32'(bus.req_ready), 32'(exp_ready));
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end

    // Reset with all four requesting, then a full round plus wrap.
    push_byte(0, 8'h10); push_byte(0, 8'h14);
    push_byte(1, 8'h11); push_byte(2, 8'h12); push_byte(3, 8'h13);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_release("rel1", 4'b0001);
    wait_drain("drain_all4", 400);
    check_eq("all4_tx_count", tx_cycles.size(), 5);
    for (int i = 1; i < tx_cycles.size(); i++)
      check_eq("all4_spacing", tx_cycles[i] - tx_cycles[i-1], HOLD_CYC + 2);

    // Single byte from requester 2.
    exp_grant.push_back(2);
    push_byte(2, 8'hA5);
    wait_drain("drain_single", 200);
    check_eq("tx_data_hold", 32'(bus.tx_data), 32'hA5);
    check_eq("grant_id_hold", 32'(bus.grant_id), 2);

    // Move pointer to 3, then sparse requests from 1 and 3.
    exp_grant.push_back(3);
    push_byte(3, 8'h33);
    wait_drain("drain_r3", 200);
    ready_seen = '0;
    exp_grant.push_back(1); exp_grant.push_back(3); exp_grant.push_back(1);
    push_byte(1, 8'h41); push_byte(1, 8'h42); push_byte(3, 8'h43);
    wait_drain("drain_sparse", 400);
    check_eq("sparse_no_ready_0_2", 32'(ready_seen & 4'b0101), 0);
    check_eq("sparse_ready_1_3", 32'(ready_seen), 32'b1010);

    // Late request raised mid-HOLD waits for IDLE.
    tx_cycles.delete();
    exp_grant.push_back(3); exp_grant.push_back(1);
    push_byte(3, 8'h11);
    wait_tx("late_first_tx", 50);
    repeat (20) @(negedge clk);
    push_byte(1, 8'h3C);
    wait_drain("drain_late", 200);
    check_eq("late_tx_count", tx_cycles.size(), 2);
    if (tx_cycles.size() == 2)
      check_eq("late_spacing", tx_cycles[1] - tx_cycles[0], HOLD_CYC + 2);

    // Reset at HOLD cycle 15: pointer returns to NUM_REQ-1 so requester 0 wins over 2.
    exp_grant.push_back(1);
    push_byte(1, 8'h77);
    wait_tx("mid_first_tx", 50);
    push_byte(2, 8'h22);
    push_byte(0, 8'h5A);
    exp_grant.push_back(0); exp_grant.push_back(2);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("tx_valid_in_reset_a", 32'(bus.tx_valid), 0);
    @(negedge clk);
    check_eq("tx_valid_in_reset_b", 32'(bus.tx_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_release("rel2", 4'b0001);
    wait_drain("drain_mid_reset", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
